reg_window_file: RTL

Parametrised SPARC V8 integer register file with a configurable number of register windows, WIM-checked SAVE/RESTORE, and state registers for icc, ET, CWP, WIM and Y. It sits between decode (read ports) and writeback (write port) and supersedes the fixed two-window register file. It adds:
- registered reads with write bypass
- a post-reset clear sequencer
- window overflow/underflow trap detection

---
 rtl/sparc_regfile_pkg.sv | 18 +
 rtl/window_addr_map.sv | 24 ++
 rtl/reg_window_file.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sparc_regfile_pkg.sv
// Shared types and the logical-to-physical window index helper for the
// windowed SPARC integer register file.
package sparc_regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } regfile_state_e;

    localparam logic WTRAP_OVF = 1'b0;
    localparam logic WTRAP_UNF = 1'b1;

    // Windowed row for logical r in 8..31; ins of window w land on outs of w+1.
    function automatic int phys_idx(input int r, input int cwp, input int nwin);
        return ((r - 8) + 16 * cwp) % (16 * nwin);
    endfunction

endpackage

// File: rtl/window_addr_map.sv
// Combinational decode of one logical register address into a global slot
// or a windowed row under the given CWP.
module window_addr_map
    import sparc_regfile_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = 3,
    parameter int WIDX_W   = 7
) (
    input  logic [4:0]        reg_i,
    input  logic [CWP_W-1:0]  cwp_i,
    output logic              glob_o,
    output logic              zero_o,
    output logic [WIDX_W-1:0] idx_o
);

    always_comb begin
        glob_o = (reg_i[4:3] == 2'b00);
        zero_o = (reg_i == 5'd0);
        if (glob_o) idx_o = WIDX_W'(reg_i[2:0]);
        else        idx_o = WIDX_W'(phys_idx(int'(reg_i), int'(cwp_i), NWINDOWS));
    end

endmodule

// File: rtl/reg_window_file.sv
// Windowed SPARC V8 integer register file: registered reads with write bypass,
// post-reset row clear, WIM-checked SAVE/RESTORE and the icc/ET/CWP/WIM/Y state.
module reg_window_file
    import sparc_regfile_pkg::*;
#(
    parameter int NWINDOWS  = 8,
    parameter int DATA_W    = 32,
    parameter int CWP_RESET = 0,
    localparam int CWP_W    = (NWINDOWS > 2) ? $clog2(NWINDOWS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [4:0]            rd,
    output logic [DATA_W-1:0]     val1,
    output logic [DATA_W-1:0]     val2,
    output logic [2*DATA_W-1:0]   val3,
    input  logic                  wr_en,
    input  logic                  wr_dbl,
    input  logic [4:0]            wr_reg,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic [3:0]            icc_in,
    input  logic                  icc_en,
    input  logic [DATA_W-1:0]     y_in,
    input  logic                  y_en,
    input  logic [NWINDOWS-1:0]   wim_in,
    input  logic                  wim_en,
    input  logic                  et_set,
    input  logic                  et_clr,
    input  logic                  save_req,
    input  logic                  restore_req,
    output logic [3:0]            icc_out,
    output logic [CWP_W-1:0]      cwp_out,
    output logic                  et_out,
    output logic [NWINDOWS-1:0]   wim_out,
    output logic [DATA_W-1:0]     y_out,
    output logic                  win_trap,
    output logic                  win_trap_uf,
    output logic                  ready
);

    localparam int NPHYS  = 16 * NWINDOWS;
    localparam int WIDX_W = $clog2(NPHYS);
    localparam int NMAP   = 6;

    regfile_state_e      state_q;
    logic [WIDX_W-1:0]   cnt_q;
    logic [CWP_W-1:0]    cwp_q;
    logic [3:0]          icc_q;
    logic                et_q;
    logic [NWINDOWS-1:0] wim_q;
    logic [DATA_W-1:0]   y_q;
    logic                trap_q, trap_uf_q;
    logic [DATA_W-1:0]   val1_q, val2_q;
    logic [2*DATA_W-1:0] val3_q;
    logic [DATA_W-1:0]   glob_q [8];
    logic [DATA_W-1:0]   win_q  [NPHYS];

    logic [NMAP-1:0][4:0]        map_reg;
    logic [NMAP-1:0]             map_glob, map_zero;
    logic [NMAP-1:0][WIDX_W-1:0] map_idx;
    logic [DATA_W-1:0]           rd_d [4];
    logic                        run, we_lo, we_hi, do_save, do_rest, trap_d;
    logic [CWP_W-1:0]            save_t, rest_t, tgt;

    // Ports 0..3 are reads (rs1, rs2, rd even, rd odd); 4/5 are the write halves.
    assign map_reg[0] = rs1;
    assign map_reg[1] = rs2;
    assign map_reg[2] = {rd[4:1], 1'b0};
    assign map_reg[3] = {rd[4:1], 1'b1};
    assign map_reg[4] = wr_dbl ? {wr_reg[4:1], 1'b0} : wr_reg;
    assign map_reg[5] = {wr_reg[4:1], 1'b1};

    for (genvar k = 0; k < NMAP; k++) begin : g_map
        window_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .WIDX_W(WIDX_W)) u_map (
            .reg_i (map_reg[k]),
            .cwp_i (cwp_q),
            .glob_o(map_glob[k]),
            .zero_o(map_zero[k]),
            .idx_o (map_idx[k])
        );
    end

    assign run     = (state_q == RUN);
    assign we_lo   = run & wr_en & ~map_zero[4];
    assign we_hi   = run & wr_en & wr_dbl & ~map_zero[5];
    assign save_t  = (cwp_q == '0) ? CWP_W'(NWINDOWS - 1) : cwp_q - 1'b1;
    assign rest_t  = (cwp_q == CWP_W'(NWINDOWS - 1)) ? '0 : cwp_q + 1'b1;
    assign do_save = run & save_req & ~restore_req;
    assign do_rest = run & restore_req & ~save_req;
    assign tgt     = do_rest ? rest_t : save_t;
    // WIM here is the pre-update value even when wim_en is high this cycle.
    assign trap_d  = (do_save | do_rest) & wim_q[tgt];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_d[k] = map_glob[k] ? glob_q[map_idx[k][2:0]] : win_q[map_idx[k]];
            if (!run || map_zero[k])
                rd_d[k] = '0;
            else if (we_hi && {map_glob[k], map_idx[k]} == {map_glob[5], map_idx[5]})
                rd_d[k] = wr_data[2*DATA_W-1:DATA_W];
            else if (we_lo && {map_glob[k], map_idx[k]} == {map_glob[4], map_idx[4]})
                rd_d[k] = wr_data[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            cwp_q     <= CWP_W'(CWP_RESET);
            icc_q     <= '0;
            et_q      <= 1'b0;
            wim_q     <= '0;
            y_q       <= '0;
            trap_q    <= 1'b0;
            trap_uf_q <= 1'b0;
            val1_q    <= '0;
            val2_q    <= '0;
            val3_q    <= '0;
            for (int g = 0; g < 8; g++) glob_q[g] <= '0;
        end else begin
            trap_q <= 1'b0;
            val1_q <= rd_d[0];
            val2_q <= rd_d[1];
            val3_q <= {rd_d[3], rd_d[2]};
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == WIDX_W'(NPHYS - 1)) state_q <= RUN;
                end
                RUN: begin
                    if (icc_en) icc_q <= icc_in;
                    if (y_en)   y_q   <= y_in;
                    if (wim_en) wim_q <= wim_in;
                    if (et_clr)      et_q <= 1'b0;
                    else if (et_set) et_q <= 1'b1;
                    if (trap_d) begin
                        trap_q    <= 1'b1;
                        trap_uf_q <= do_rest ? WTRAP_UNF : WTRAP_OVF;
                    end else if (do_save || do_rest) begin
                        cwp_q <= tgt;
                    end
                    if (we_lo && map_glob[4]) glob_q[map_idx[4][2:0]] <= wr_data[DATA_W-1:0];
                    if (we_hi && map_glob[5]) glob_q[map_idx[5][2:0]] <= wr_data[2*DATA_W-1:DATA_W];
                end
                default: state_q <= INIT;
            endcase
        end
    end

    // Windowed rows carry no reset; INIT sweeps them to zero instead.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            win_q[cnt_q] <= '0;
        end else begin
            if (we_lo && !map_glob[4]) win_q[map_idx[4]] <= wr_data[DATA_W-1:0];
            if (we_hi && !map_glob[5]) win_q[map_idx[5]] <= wr_data[2*DATA_W-1:DATA_W];
        end
    end

    assign val1        = val1_q;
    assign val2        = val2_q;
    assign val3        = val3_q;
    assign icc_out     = icc_q;
    assign cwp_out     = cwp_q;
    assign et_out      = et_q;
    assign wim_out     = wim_q;
    assign y_out       = y_q;
    assign win_trap    = trap_q;
    assign win_trap_uf = trap_uf_q;
    assign ready       = run;

endmodule
